// File: rtl/iccm_boot_pkg.sv
// Shared types and default widths for the ICCM boot arbiter.
// This package covers the boot state encoding and the ICCM word-address and data width defaults.
package iccm_boot_pkg;

  localparam int ICCM_AW_DEF = 12;
  localparam int ICCM_DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } boot_st_e;

endpackage

// File: rtl/iccm_boot_arbiter_if.sv
// Host-side SRAM request bus between the TL-UL SRAM adapter and the ICCM boot arbiter.
interface iccm_boot_arbiter_if
  import iccm_boot_pkg::*;
#(
  parameter int AW = ICCM_AW_DEF,
  parameter int DW = ICCM_DW_DEF
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] wmask;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (output req, we, addr, wdata, wmask, input gnt, rdata, rvalid);
  modport slave  (input req, we, addr, wdata, wmask, output gnt, rdata, rvalid);

endinterface

// File: rtl/iccm_boot_arbiter.sv
// Shares the single ICCM SRAM port between the UART boot loader and the core-side adapter,
// sequencing boot (load first, then release the core) and tracking host reads in flight.
module iccm_boot_arbiter
  import iccm_boot_pkg::*;
#(
  parameter int AW          = ICCM_AW_DEF,
  parameter int DW          = ICCM_DW_DEF,
  parameter int Outstanding = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          boot_sel_i,
  input  logic          ldr_we_i,
  input  logic [AW-1:0] ldr_addr_i,
  input  logic [DW-1:0] ldr_wdata_i,
  input  logic          ldr_done_i,
  iccm_boot_arbiter_if.slave host,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [DW-1:0] mem_wmask_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_rvalid_i,
  output logic          core_rst_no,
  output logic [AW:0]   load_cnt_o,
  output logic          ldr_err_o
);

  localparam int CW = $clog2(Outstanding + 1);
  localparam logic [AW:0]   LoadMax = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] RdMax   = CW'(Outstanding);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic          ldr_err_q, ldr_err_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          in_load, in_run, rd_full, rd_grant, rd_ret;

  assign in_load = (state_q == ST_LOAD);
  assign in_run  = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:   state_d = boot_sel_i ? ST_LOAD : ST_RUN;
      ST_LOAD:    if (ldr_done_i) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  // A return in the same cycle frees a slot, so a full tracker can still grant.
  assign rd_full     = (rd_cnt_q == RdMax) & ~mem_rvalid_i;
  assign host.gnt    = in_run & host.req & ~rd_full;
  assign rd_grant    = host.gnt & ~host.we;
  assign rd_ret      = mem_rvalid_i & (rd_cnt_q != '0);
  assign host.rvalid = rd_ret;
  assign host.rdata  = mem_rdata_i;
  assign core_rst_no = in_run;
  assign load_cnt_o  = load_cnt_q;
  assign ldr_err_o   = ldr_err_q;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (in_load) begin
      mem_req_o   = ldr_we_i;
      mem_we_o    = ldr_we_i;
      mem_addr_o  = ldr_addr_i;
      mem_wdata_o = ldr_wdata_i;
      mem_wmask_o = '1;
    end else if (in_run) begin
      mem_req_o   = host.req & host.gnt;
      mem_we_o    = host.we & host.req & host.gnt;
      mem_addr_o  = host.addr;
      mem_wdata_o = host.wdata;
      mem_wmask_o = host.wmask;
    end
  end

  always_comb begin
    load_cnt_d = load_cnt_q;
    if (in_load && ldr_we_i && (load_cnt_q != LoadMax)) begin
      load_cnt_d = load_cnt_q + 1'b1;
    end
    ldr_err_d = ldr_err_q | (ldr_we_i & ~in_load);
    rd_cnt_d  = rd_cnt_q;
    case ({rd_grant, rd_ret})
      2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
      2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RESET;
      load_cnt_q <= '0;
      ldr_err_q  <= 1'b0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      ldr_err_q  <= ldr_err_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

endmodule

// File: doc/iccm_boot_arbiter.md
# iccm_boot_arbiter

Owns the single SRAM port of the instruction memory (ICCM) and shares it between the UART boot loader (`iccm_controller` write stream) and the core-side TL-UL SRAM adapter. After reset it sequences boot: with load strap set, the loader owns the port while the core is held in reset; once the loader signals completion the port is handed to the adapter and the core is released. Sits between `iccm_controller`/`tlul_sram_adapter` and `instr_mem_top` inside `azadi_soc_top`.

## Interface
- `AW`, 12: ICCM word-address width.
- `DW`, 32: data width.
- `Outstanding`, 2: maximum host reads in flight (1..3).
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `boot_sel_i`  in  1  strap: 1 = load over UART first, 0 = run directly.
- `ldr_we_i`  in  1  loader write strobe (one word per cycle high).
- `ldr_addr_i`  in  AW  loader word address.
- `ldr_wdata_i`  in  DW  loader write data.
- `ldr_done_i`  in  1  loader end-of-image pulse.
- `host_req_i`  in  1  adapter request.
- `host_we_i`  in  1  adapter write.
- `host_addr_i`  in  AW  adapter address.
- `host_wdata_i`  in  DW  adapter write data.
- `host_wmask_i`  in  DW  adapter bit mask.
- `host_gnt_o`  out  1  adapter grant.
- `host_rdata_o`  out  DW  read data to adapter.
- `host_rvalid_o`  out  1  read data valid.
- `mem_req_o`, `mem_we_o`  out  1  SRAM request / write enable.
- `mem_addr_o`  out  AW; `mem_wdata_o`, `mem_wmask_o`  out  DW.
- `mem_rdata_i`  in  DW; `mem_rvalid_i`  in  1  SRAM read return (fixed 1-cycle latency).
- `core_rst_no`  out  1  core reset, active-low.
- `load_cnt_o`  out  AW+1  words written by loader, saturating.
- `ldr_err_o`  out  1  sticky: loader write arrived outside LOAD.

## Operation
- FSM states: `ST_RESET`, `ST_LOAD`, `ST_RELEASE`, `ST_RUN`.
- `ST_RESET` (one cycle after reset deassert): sample `boot_sel_i`; 1 -> `ST_LOAD`, 0 -> `ST_RUN`.
- `ST_LOAD`: `mem_*` driven from loader (`mem_req_o = mem_we_o = ldr_we_i`, `mem_wmask_o` all ones); `host_gnt_o = 0`; `core_rst_no = 0`; each `ldr_we_i` increments `load_cnt_o` (saturates at 2^AW). `ldr_done_i` -> `ST_RELEASE`; a write in the same cycle as `ldr_done_i` is performed and counted.
- `ST_RELEASE`: one cycle, port idle, `core_rst_no` still 0 -> `ST_RUN`.
- `ST_RUN`: terminal until reset. `core_rst_no = 1`; `mem_*` driven from host; `host_gnt_o = host_req_i & ~rd_full`, `mem_req_o = host_req_i & host_gnt_o`. Loader writes are dropped and set `ldr_err_o`; `ldr_done_i` ignored.
- Read tracking: counter `rd_cnt` (0..Outstanding) +1 on granted read, -1 on `mem_rvalid_i`, both -> unchanged. `rd_full = (rd_cnt == Outstanding) & ~mem_rvalid_i`.
- `host_rvalid_o = mem_rvalid_i & (rd_cnt != 0)`; `host_rdata_o = mem_rdata_i`. Stray `mem_rvalid_i` with `rd_cnt == 0` is discarded.
- Writes from host produce no `host_rvalid_o`.

## Timing
- Reset values: state `ST_RESET`, `core_rst_no = 0`, `host_gnt_o = 0`, `mem_req_o = 0`, `mem_we_o = 0`, `host_rvalid_o = 0`, `load_cnt_o = 0`, `ldr_err_o = 0`, `rd_cnt = 0`.
- `mem_*` combinational from the owning requester (0 latency); grant same cycle as request.
- `core_rst_no` rises 2 cycles after `ldr_done_i` (LOAD -> RELEASE -> RUN), 1 cycle after reset release when `boot_sel_i = 0`.
- Read data returns 1 cycle after grant; back-to-back reads sustain 1/cycle.
- Reset mid-load: all state cleared, `core_rst_no` low immediately (async), load restarts from `ST_RESET`.

## Structure
- `iccm_boot_pkg`: state enum `boot_st_e`, `ICCM_AW_DEF`, `ICCM_DW_DEF`.
- Single flat module; no sub-module required.

## Test plan
- `boot_sel_i = 0`, reset release -> `core_rst_no = 1` at cycle 2; host read addr 0x010 granted same cycle; `host_rvalid_o` next cycle with SRAM data.
- `boot_sel_i = 1`, loader writes 0x00..0x03 data 0xA0..0xA3, `ldr_done_i` -> `load_cnt_o = 4`, `core_rst_no` rises 2 cycles after done, host reads return 0xA0..0xA3.
- `host_req_i` held during LOAD -> `host_gnt_o = 0` throughout, `mem_we_o` only from loader.
- 3 back-to-back reads with `Outstanding = 2` and `mem_rvalid_i` held low -> third not granted until a return arrives.
- Loader write in RUN -> no SRAM write, `ldr_err_o = 1` sticky; `ldr_we_i` and `ldr_done_i` same cycle -> write counted, transition taken.
- Assert `rst_ni` low mid-load after 2 words -> outputs at reset values asynchronously, `load_cnt_o = 0`.
